// File: rtl/mem_channel_arbiter_if.sv
// Bus bundle between two HLS accelerator memory ports, the channel arbiter and the RAM model.
// The arbiter takes the slave view: master request fields and memory responses come in,
// while arbitrated memory requests and per-master responses go out.
interface mem_channel_arbiter_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SIZE_W = 6
);
    // Accelerator side, master i occupies slice i of each packed field
    logic [1:0]          m_oe;
    logic [1:0]          m_we;
    logic [2*ADDR_W-1:0] m_addr;
    logic [2*DATA_W-1:0] m_wdata;
    logic [2*SIZE_W-1:0] m_size;
    logic [2*DATA_W-1:0] m_rdata;
    logic [1:0]          m_datardy;

    // Memory side
    logic                mem_oe;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [SIZE_W-1:0]   mem_size;
    logic [DATA_W-1:0]   mem_rdata;
    logic                mem_datardy;

    // Sticky watchdog status
    logic                arb_err;

    // Environment view: accelerators and RAM model
    modport master (
        output m_oe, m_we, m_addr, m_wdata, m_size, mem_rdata, mem_datardy,
        input  m_rdata, m_datardy, mem_oe, mem_we, mem_addr, mem_wdata, mem_size, arb_err
    );

    // Arbiter view
    modport slave (
        input  m_oe, m_we, m_addr, m_wdata, m_size, mem_rdata, mem_datardy,
        output m_rdata, m_datardy, mem_oe, mem_we, mem_addr, mem_wdata, mem_size, arb_err
    );
endinterface

// File: rtl/mem_channel_arbiter.sv
// Two-master round-robin arbiter for one Bambu external memory channel.
// A grant is taken one cycle after a request appears and is held until the memory returns
// DataRdy; a pending request from the other master is then granted with no idle cycle.
// Optional feature macro: ARB_WATCHDOG_EN adds a completion watchdog of TIMEOUT_CYC cycles
// that forces a zero-data completion and sets the sticky arb_err flag.
module mem_channel_arbiter #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned SIZE_W      = 6,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                  clock_i,
    input  logic                  reset_ni,
    mem_channel_arbiter_if.slave  bus_io
);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e state_q, state_d;
    logic   gnt_q, gnt_d;
    logic   rr_q, rr_d;

    logic [1:0] req;
    logic       busy;
    logic       wd_fire;
    logic       done;

    logic [2*DATA_W-1:0] m_rdata;
    logic [1:0]          m_datardy;
    logic                mem_oe;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [SIZE_W-1:0]   mem_size;

    assign req  = bus_io.m_oe | bus_io.m_we;
    assign busy = (state_q == StBusy);
    // A forced watchdog completion is treated exactly like a real DataRdy
    assign done = busy & (bus_io.mem_datardy | wd_fire);

`ifdef ARB_WATCHDOG_EN
    localparam int unsigned WdW = $clog2(TIMEOUT_CYC);
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYC - 1);

    logic [WdW-1:0] wd_cnt_q, wd_cnt_d;
    logic           arb_err_q, arb_err_d;

    assign wd_fire = busy & ~bus_io.mem_datardy & (wd_cnt_q == WdLast);

    // Watchdog count: zero while idle (so BUSY entry starts at 0), cleared on each completion
    always_comb begin
        wd_cnt_d  = wd_cnt_q;
        arb_err_d = arb_err_q | wd_fire;
        if (!busy || done) begin
            wd_cnt_d = '0;
        end else begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end
    end

    // Watchdog state registers
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wd_cnt_q  <= '0;
            arb_err_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            arb_err_q <= arb_err_d;
        end
    end

    assign bus_io.arb_err = arb_err_q;
`else
    assign wd_fire        = 1'b0;
    assign bus_io.arb_err = 1'b0;
`endif

    // Arbitration state registers
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= StIdle;
            gnt_q   <= 1'b0;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
        end
    end

    // Next-state: grant on request while idle, hand over or release on completion
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        unique case (state_q)
            StIdle: begin
                if (req == 2'b11) begin
                    state_d = StBusy;
                    gnt_d   = rr_q;
                end else if (req[0]) begin
                    state_d = StBusy;
                    gnt_d   = 1'b0;
                end else if (req[1]) begin
                    state_d = StBusy;
                    gnt_d   = 1'b1;
                end
            end
            StBusy: begin
                if (done) begin
                    rr_d = ~gnt_q;
                    // The completing master is still dropping its request, so only the
                    // other master can be granted here
                    if (req[~gnt_q]) begin
                        gnt_d = ~gnt_q;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output mux: forward the granted master while busy, everything zero while idle
    always_comb begin
        mem_oe    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_size  = '0;
        m_datardy = 2'b00;
        m_rdata   = '0;
        if (busy) begin
            if (gnt_q) begin
                mem_oe    = bus_io.m_oe[1];
                mem_we    = bus_io.m_we[1];
                mem_addr  = bus_io.m_addr[2*ADDR_W-1:ADDR_W];
                mem_wdata = bus_io.m_wdata[2*DATA_W-1:DATA_W];
                mem_size  = bus_io.m_size[2*SIZE_W-1:SIZE_W];
                m_datardy[1] = done;
                // Forced watchdog completions carry zero data
                if (bus_io.mem_datardy) begin
                    m_rdata[2*DATA_W-1:DATA_W] = bus_io.mem_rdata;
                end
            end else begin
                mem_oe    = bus_io.m_oe[0];
                mem_we    = bus_io.m_we[0];
                mem_addr  = bus_io.m_addr[ADDR_W-1:0];
                mem_wdata = bus_io.m_wdata[DATA_W-1:0];
                mem_size  = bus_io.m_size[SIZE_W-1:0];
                m_datardy[0] = done;
                if (bus_io.mem_datardy) begin
                    m_rdata[DATA_W-1:0] = bus_io.mem_rdata;
                end
            end
        end
    end

    assign bus_io.mem_oe    = mem_oe;
    assign bus_io.mem_we    = mem_we;
    assign bus_io.mem_addr  = mem_addr;
    assign bus_io.mem_wdata = mem_wdata;
    assign bus_io.mem_size  = mem_size;
    assign bus_io.m_datardy = m_datardy;
    assign bus_io.m_rdata   = m_rdata;

endmodule
